// File: rtl/alu_result_checker_if.sv
// alu_result_checker_if: observed ALU transaction handshake into the checker
interface alu_result_checker_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH-1:0] s;
    logic             n;
    logic             z;
    logic             c;
    logic             v;
    modport master (output in_valid, a, b, m, s, n, z, c, v, input in_ready);
    modport slave  (input in_valid, a, b, m, s, n, z, c, v, output in_ready);
endinterface

// File: rtl/alu_result_checker.sv
// alu_result_checker: recomputes ALU add/sub results and flags, counts and captures mismatches
module alu_result_checker #(
    parameter int WIDTH       = 16,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    alu_result_checker_if.slave  bus,
    output logic                 chk_valid,
    output logic                 chk_err,
    output logic [4:0]           err_mask,
    output logic [CNT_W-1:0]     txn_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 first_err,
    output logic [WIDTH-1:0]     cap_a,
    output logic [WIDTH-1:0]     cap_b,
    output logic [WIDTH-1:0]     cap_s,
    output logic                 cap_m,
    output logic [1:0]           state
);
    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10;
    logic [1:0]       state_q, state_d;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [3:0]       gold_f;
    logic             v1_q;
    logic [WIDTH-1:0] a1_q, b1_q, s1_q, gs_q;
    logic             m1_q;
    logic [3:0]       obs_q, gf_q;
    logic [4:0]       mask_d;
    logic             fail_now, cap_hit;
    logic [CNT_W-1:0] txn_q, txn_d, ecnt_q, ecnt_d;
    logic             first_q;
    logic [WIDTH-1:0] cap_a_q, cap_b_q, cap_s_q;
    logic             cap_m_q;

    // golden add/subtract in WIDTH+1 bits and its N/Z/C/V flags
    always_comb begin
        accept = bus.in_valid & bus.in_ready;
        b_eff  = bus.m ? ~bus.b : bus.b;
        sum    = {1'b0, bus.a} + {1'b0, b_eff} + (WIDTH+1)'(bus.m);
        gold_f = {sum[WIDTH-1], sum[WIDTH-1:0] == '0, sum[WIDTH],
                  (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1])};
    end

    // stage 1: hold the accepted observation next to its golden values
    always_ff @(posedge clk) begin
        v1_q <= rst_n && !clear && accept;
        if (accept) begin
            a1_q  <= bus.a;
            b1_q  <= bus.b;
            m1_q  <= bus.m;
            s1_q  <= bus.s;
            obs_q <= {bus.n, bus.z, bus.c, bus.v};
            gs_q  <= sum[WIDTH-1:0];
            gf_q  <= gold_f;
        end
    end

    // per-field compare of stage 1 and the bookkeeping that depends on it
    always_comb begin
        mask_d   = {s1_q != gs_q, obs_q ^ gf_q};
        fail_now = v1_q && (|mask_d);
        cap_hit  = fail_now && !first_q;
        txn_d    = (accept && !(&txn_q)) ? txn_q + CNT_W'(1) : txn_q;
        ecnt_d   = (fail_now && !(&ecnt_q)) ? ecnt_q + CNT_W'(1) : ecnt_q;
    end

    // stage 2: registered comparison result, one cycle after accept
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            chk_valid <= 1'b0;
            chk_err   <= 1'b0;
            err_mask  <= '0;
        end else begin
            chk_valid <= v1_q;
            chk_err   <= fail_now;
            err_mask  <= v1_q ? mask_d : '0;
        end
    end

    // saturating counters and first-failure capture
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            txn_q   <= '0;
            ecnt_q  <= '0;
            first_q <= 1'b0;
            cap_a_q <= '0;
            cap_b_q <= '0;
            cap_s_q <= '0;
            cap_m_q <= 1'b0;
        end else begin
            txn_q  <= txn_d;
            ecnt_q <= ecnt_d;
            if (cap_hit) begin
                first_q <= 1'b1;
                cap_a_q <= a1_q;
                cap_b_q <= b1_q;
                cap_s_q <= s1_q;
                cap_m_q <= m1_q;
            end
        end
    end

    // fsm state register
    always_ff @(posedge clk) begin
        state_q <= rst_n ? state_d : IDLE;
    end

    // fsm next state: clear wins, HOLD only leaves through clear
    always_comb begin
        state_d = clear ? IDLE :
                  (state_q == IDLE && start) ? RUN :
                  (state_q == RUN && fail_now && STOP_ON_ERR) ? HOLD : state_q;
    end

    // fsm outputs
    always_comb begin
        bus.in_ready = (state_q == RUN);
        state        = state_q;
    end

    assign txn_cnt   = txn_q;
    assign err_cnt   = ecnt_q;
    assign first_err = first_q;
    assign cap_a     = cap_a_q;
    assign cap_b     = cap_b_q;
    assign cap_s     = cap_s_q;
    assign cap_m     = cap_m_q;
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: scoreboard bench for two checker configurations
module tb_alu_result_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n, start, clear;
    alu_result_checker_if #(.WIDTH(16)) if0();
    alu_result_checker_if #(.WIDTH(16)) if1();
    logic        c0_valid, c0_err, f0, cm0, c1_valid, c1_err, f1, cm1;
    logic [4:0]  m0_mask, m1_mask;
    logic [15:0] t0, e0, ca0, cb0, cs0, ca1, cb1, cs1;
    logic [3:0]  t1, e1;
    logic [1:0]  st0, st1;
    int tests = 0, fails = 0;
    logic [5:0] q0[$], q1[$];

    alu_result_checker #(.WIDTH(16), .CNT_W(16), .STOP_ON_ERR(1'b1)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .bus(if0.slave),
        .chk_valid(c0_valid), .chk_err(c0_err), .err_mask(m0_mask), .txn_cnt(t0), .err_cnt(e0),
        .first_err(f0), .cap_a(ca0), .cap_b(cb0), .cap_s(cs0), .cap_m(cm0), .state(st0));

    alu_result_checker #(.WIDTH(16), .CNT_W(4), .STOP_ON_ERR(1'b0)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .bus(if1.slave),
        .chk_valid(c1_valid), .chk_err(c1_err), .err_mask(m1_mask), .txn_cnt(t1), .err_cnt(e1),
        .first_err(f1), .cap_a(ca1), .cap_b(cb1), .cap_s(cs1), .cap_m(cm1), .state(st1));

    function automatic logic [19:0] gold(input logic [15:0] a, input logic [15:0] b, input logic m);
        int ua, ub, sa, sb, ur, sr;
        logic [15:0] s;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = m ? ua - ub : ua + ub;
        sr = m ? sa - sb : sa + sb;
        s  = ur[15:0];
        c  = m ? (ua >= ub) : (ur > 65535);
        v  = (sr > 32767) || (sr < -32768);
        return {s, s[15], s == 16'd0, c, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (c0_valid === 1'b1) begin
            logic [5:0] e;
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL d0 unexpected chk_valid: err=%b mask=%b", c0_err, m0_mask);
            end else begin
                e = q0.pop_front();
                if ({c0_err, m0_mask} !== e) begin
                    fails++;
                    $display("FAIL d0 chk: got err=%b mask=%b expected err=%b mask=%b", c0_err, m0_mask, e[5], e[4:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (c1_valid === 1'b1) begin
            logic [5:0] e;
            tests++;
            if (q1.size() == 0) begin
                fails++;
                $display("FAIL d1 unexpected chk_valid: err=%b mask=%b", c1_err, m1_mask);
            end else begin
                e = q1.pop_front();
                if ({c1_err, m1_mask} !== e) begin
                    fails++;
                    $display("FAIL d1 chk: got err=%b mask=%b expected err=%b mask=%b", c1_err, m1_mask, e[5], e[4:0]);
                end
            end
        end
    end

    task automatic send(input bit sel, input logic [15:0] a, input logic [15:0] b, input logic m,
                        input logic [15:0] s, input logic [3:0] f, output bit acc, output bit err);
        logic [19:0] g;
        logic [4:0]  mk;
        g  = gold(a, b, m);
        mk = {g[19:4] != s, g[3:0] ^ f};
        @(negedge clk);
        if (!sel) begin
            if0.in_valid = 1'b1; if0.a = a; if0.b = b; if0.m = m; if0.s = s;
            {if0.n, if0.z, if0.c, if0.v} = f;
            acc = if0.in_ready;
            if (acc) q0.push_back({|mk, mk});
        end else begin
            if1.in_valid = 1'b1; if1.a = a; if1.b = b; if1.m = m; if1.s = s;
            {if1.n, if1.z, if1.c, if1.v} = f;
            acc = if1.in_ready;
            if (acc) q1.push_back({|mk, mk});
        end
        err = acc && (|mk);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit do_start, input bit do_clear);
        @(negedge clk);
        start = do_start;
        clear = do_clear;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        bit acc, er;
        int nerr;
        logic [15:0] ra, rb, rs;
        logic rm;
        logic [3:0] rf;
        logic [19:0] g;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.m = 1'b0; if0.s = '0;
        {if0.n, if0.z, if0.c, if0.v} = 4'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.m = 1'b0; if1.s = '0;
        {if1.n, if1.z, if1.c, if1.v} = 4'b0;
        repeat (3) @(negedge clk);
        check("rst state", 32'(st0), 0);
        check("rst in_ready", 32'(if0.in_ready), 0);
        check("rst chk", {c0_valid, c0_err, m0_mask}, 0);
        check("rst cnts", {t0, e0}, 0);
        check("rst capture", {f0, ca0, cs0}, 0);
        rst_n = 1'b1;

        pulse(1, 0);
        check("start state", 32'(st0), 1);
        check("start in_ready", 32'(if0.in_ready), 1);
        send(0, 16'h1234, 16'h4321, 0, 16'h5555, 4'b0000, acc, er);
        @(negedge clk);
        if0.in_valid = 1'b0;
        check("lat no valid yet", 32'(c0_valid), 0);
        check("txn after accept", 32'(t0), 1);
        @(negedge clk);
        check("lat valid", {c0_valid, c0_err}, 2'b10);
        check("err_cnt pass", 32'(e0), 0);

        send(0, 16'h1234, 16'h4321, 1, 16'hCF13, 4'b1000, acc, er);
        send(0, 16'h1234, 16'h4321, 1, 16'hCF13, 4'b1010, acc, er);
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(negedge clk);
        check("c mismatch mask", {c0_err, m0_mask}, 6'b100010);
        idle(1);
        check("hold capture", {f0, cm0, ca0, cb0, cs0}, {2'b11, 16'h1234, 16'h4321, 16'hCF13});
        check("hold state", 32'(st0), 2);
        check("hold in_ready", 32'(if0.in_ready), 0);
        check("hold cnts", {t0, e0}, {16'd3, 16'd1});
        pulse(1, 0);
        check("hold ignores start", 32'(st0), 2);

        pulse(0, 1);
        check("clear state", 32'(st0), 0);
        check("clear cnts capture", {t0, e0, f0, cs0}, 0);
        pulse(1, 0);
        send(0, 16'h7FFF, 16'h0001, 0, 16'h8000, 4'b1001, acc, er);
        send(0, 16'h8000, 16'h0001, 1, 16'h7FFF, 4'b0011, acc, er);
        send(0, 16'hABCD, 16'hABCD, 1, 16'h0000, 4'b0110, acc, er);
        idle(2);
        check("corners cnts", {t0, e0}, {16'd3, 16'd0});
        check("corners state", 32'(st0), 1);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
            g = gold(ra, rb, rm);
            send(0, ra, rb, rm, g[19:4], g[3:0], acc, er);
        end
        idle(2);
        check("random pass cnts", {t0, e0}, {16'd43, 16'd0});

        pulse(0, 1);
        pulse(1, 0);
        send(0, 16'h0100, 16'h0200, 0, 16'h0301, 4'b0000, acc, er);
        send(0, 16'h7000, 16'h1000, 0, 16'h8000, 4'b1000, acc, er);
        send(0, 16'h0001, 16'h0001, 0, 16'h0002, 4'b0000, acc, er);
        check("no accept in hold", 32'(acc), 0);
        idle(2);
        check("inflight cnts", {t0, e0}, {16'd2, 16'd2});
        check("inflight not captured", {ca0, cs0}, {16'h0100, 16'h0301});
        check("inflight state", 32'(st0), 2);

        pulse(0, 1);
        pulse(1, 0);
        send(1, 16'h0010, 16'h0020, 0, 16'h0030, 4'b0000, acc, er);
        send(1, 16'h0050, 16'h0060, 1, 16'h1234, 4'b1000, acc, er);
        send(1, 16'hFFFF, 16'h0001, 0, 16'h0000, 4'b0110, acc, er);
        send(1, 16'h8000, 16'h0001, 1, 16'h7FFF, 4'b0010, acc, er);
        check("stream in_ready", 32'(if1.in_ready), 1);
        idle(2);
        check("stream cnts", {t1, e1}, {4'd4, 4'd2});
        check("stream capture", {f1, cm1, ca1, cs1}, {2'b11, 16'h0050, 16'h1234});
        check("stream state", 32'(st1), 1);
        nerr = 2;
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
            g = gold(ra, rb, rm);
            rs = g[19:4];
            rf = g[3:0];
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, 4));
                if (k == 4) rs = rs ^ (16'd1 << $urandom_range(0, 15));
                else rf[k] = ~rf[k];
            end
            send(1, ra, rb, rm, rs, rf, acc, er);
            if (er) nerr++;
        end
        idle(2);
        check("sat txn", 32'(t1), 15);
        check("sat err", 32'(e1), (nerr > 15) ? 15 : nerr);
        check("sat capture kept", {ca1, cs1}, {16'h0050, 16'h1234});

        send(0, 16'h0003, 16'h0004, 0, 16'h0007, 4'b0000, acc, er);
        idle(2);
        check("pre reset txn", 32'(t0), 1);
        send(0, 16'h0005, 16'h0006, 0, 16'h000B, 4'b0000, acc, er);
        @(negedge clk);
        if0.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        q0.delete();
        q1.delete();
        @(negedge clk);
        check("midrst chk", {c0_valid, c0_err, m0_mask}, 0);
        check("midrst d0", {st0, if0.in_ready, t0, e0}, 0);
        check("midrst d1", {st1, t1, e1, f1, ca1, cs1}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst no late chk", 32'(c0_valid), 0);

        pulse(1, 0);
        check("run again", 32'(st0), 1);
        pulse(1, 1);
        check("clear beats start", 32'(st0), 0);
        idle(3);
        check("scoreboard drained", q0.size() + q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
